// File: rtl/apb_master_bridge.sv
// APB requester: turns a valid/ready command into one APB SETUP/ACCESS transfer and returns a response.
// Optional ACCESS-phase timeout is enabled by defining APB_TIMEOUT_EN.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module apb_master_bridge #(
  parameter int ADDR_WIDTH     = `ADDR_WIDTH,
  parameter int DATA_WIDTH     = `DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic                  PWRITE,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t                state_reg, state_next;
  logic                  psel_reg, psel_next;
  logic                  penable_reg, penable_next;
  logic                  pwrite_reg, pwrite_next;
  logic [ADDR_WIDTH-1:0] paddr_reg, paddr_next;
  logic [DATA_WIDTH-1:0] pwdata_reg, pwdata_next;
  logic                  rsp_valid_reg, rsp_valid_next;
  logic [DATA_WIDTH-1:0] rsp_rdata_reg, rsp_rdata_next;
  logic                  rsp_err_reg, rsp_err_next;

`ifdef APB_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);
  logic [15:0] wait_cnt_reg, wait_cnt_next, wait_cnt_inc;
`endif

  // Gated by reset so no command is offered while the bus is held in reset.
  assign cmd_ready = PRESETn && (state_reg == IDLE);

  always_comb begin
    state_next     = state_reg;
    psel_next      = psel_reg;
    penable_next   = penable_reg;
    pwrite_next    = pwrite_reg;
    paddr_next     = paddr_reg;
    pwdata_next    = pwdata_reg;
    rsp_valid_next = rsp_valid_reg;
    rsp_rdata_next = rsp_rdata_reg;
    rsp_err_next   = rsp_err_reg;
`ifdef APB_TIMEOUT_EN
    wait_cnt_next  = wait_cnt_reg;
    wait_cnt_inc   = wait_cnt_reg + 16'd1;
`endif
    case (state_reg)
      IDLE: begin
        if (cmd_valid) begin
          paddr_next  = cmd_addr;
          pwrite_next = cmd_write;
          pwdata_next = cmd_wdata;
          psel_next   = 1'b1;
          state_next  = SETUP;
        end
      end
      SETUP: begin
        penable_next = 1'b1;
        state_next   = ACCESS;
`ifdef APB_TIMEOUT_EN
        wait_cnt_next = 16'd0;
`endif
      end
      ACCESS: begin
        if (PREADY) begin
          rsp_rdata_next = pwrite_reg ? '0 : PRDATA;
          rsp_err_next   = PSLVERR;
          psel_next      = 1'b0;
          penable_next   = 1'b0;
          rsp_valid_next = 1'b1;
          state_next     = RESP;
        end
`ifdef APB_TIMEOUT_EN
        else begin
          wait_cnt_next = wait_cnt_inc;
          // Abort on the wait cycle that brings the count to the limit.
          if (wait_cnt_inc >= TIMEOUT_LIM) begin
            rsp_rdata_next = '0;
            rsp_err_next   = 1'b1;
            psel_next      = 1'b0;
            penable_next   = 1'b0;
            rsp_valid_next = 1'b1;
            state_next     = RESP;
          end
        end
`endif
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_next = 1'b0;
          state_next     = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_reg     <= IDLE;
      psel_reg      <= 1'b0;
      penable_reg   <= 1'b0;
      pwrite_reg    <= 1'b0;
      paddr_reg     <= '0;
      pwdata_reg    <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= '0;
      rsp_err_reg   <= 1'b0;
`ifdef APB_TIMEOUT_EN
      wait_cnt_reg  <= 16'd0;
`endif
    end else begin
      state_reg     <= state_next;
      psel_reg      <= psel_next;
      penable_reg   <= penable_next;
      pwrite_reg    <= pwrite_next;
      paddr_reg     <= paddr_next;
      pwdata_reg    <= pwdata_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_rdata_reg <= rsp_rdata_next;
      rsp_err_reg   <= rsp_err_next;
`ifdef APB_TIMEOUT_EN
      wait_cnt_reg  <= wait_cnt_next;
`endif
    end
  end

  assign PSEL      = psel_reg;
  assign PENABLE   = penable_reg;
  assign PWRITE    = pwrite_reg;
  assign PADDR     = paddr_reg;
  assign PWDATA    = pwdata_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_rdata = rsp_rdata_reg;
  assign rsp_err   = rsp_err_reg;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge: reset, zero-wait write, waited read, error with backpressure,
// reset during ACCESS, and either the timeout (APB_TIMEOUT_EN) or the unbounded-wait behaviour.
module tb_apb_master_bridge;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        PSEL;
  logic        PENABLE;
  logic [31:0] PADDR;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  int total = 0;
  int bad   = 0;

  apb_master_bridge #(
    .ADDR_WIDTH    (32),
    .DATA_WIDTH    (32),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .PCLK     (PCLK),
    .PRESETn  (PRESETn),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr (cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .PSEL     (PSEL),
    .PENABLE  (PENABLE),
    .PADDR    (PADDR),
    .PWRITE   (PWRITE),
    .PWDATA   (PWDATA),
    .PRDATA   (PRDATA),
    .PREADY   (PREADY),
    .PSLVERR  (PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic test_reset();
    PRESETn = 1'b0; cmd_valid = 1'b1; cmd_write = 1'b1;
    cmd_addr = 32'h55; cmd_wdata = 32'h1234; rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if ({PSEL, PENABLE, PWRITE, rsp_valid, rsp_err, cmd_ready} !== 6'b0) begin
        bad++;
        $display("FAIL reset_ctrl[%0d]: got sel/en/wr/rv/err/rdy=%b want 000000", i,
                 {PSEL, PENABLE, PWRITE, rsp_valid, rsp_err, cmd_ready});
      end
      total++;
      if ({PADDR, PWDATA, rsp_rdata} !== 96'h0) begin
        bad++;
        $display("FAIL reset_data[%0d]: got addr=%h wdata=%h rdata=%h want 0", i, PADDR, PWDATA, rsp_rdata);
      end
    end
    cmd_valid = 1'b0;
    PRESETn   = 1'b1;
    #1;
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_release_ready: got %b want 1", cmd_ready);
    end
    tick();
    total++;
    if ({cmd_ready, PSEL} !== 2'b10) begin
      bad++;
      $display("FAIL reset_idle: got rdy/sel=%b want 10", {cmd_ready, PSEL});
    end
    $display("reset: done");
  endtask

  task automatic test_write_zero_wait();
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h10; cmd_wdata = 32'hDEADBEEF;
    PREADY = 1'b1; PRDATA = 32'hAAAA5555; PSLVERR = 1'b0; rsp_ready = 1'b1;
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL wr_accept_ready: got %b want 1", cmd_ready);
    end
    tick();
    cmd_valid = 1'b0;
    total++;
    if ({PSEL, PENABLE, PWRITE, cmd_ready} !== 4'b1010 || PADDR !== 32'h10 || PWDATA !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL wr_setup: got sel/en/wr/rdy=%b addr=%h wdata=%h want 1010 10 deadbeef",
               {PSEL, PENABLE, PWRITE, cmd_ready}, PADDR, PWDATA);
    end
    tick();
    total++;
    if ({PSEL, PENABLE, PWRITE} !== 3'b111 || PADDR !== 32'h10 || PWDATA !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL wr_access: got sel/en/wr=%b addr=%h wdata=%h want 111 10 deadbeef",
               {PSEL, PENABLE, PWRITE}, PADDR, PWDATA);
    end
    tick();
    total++;
    if ({rsp_valid, rsp_err, PSEL, PENABLE} !== 4'b1000 || rsp_rdata !== 32'h0) begin
      bad++;
      $display("FAIL wr_resp: got rv/err/sel/en=%b rdata=%h want 1000 0", {rsp_valid, rsp_err, PSEL, PENABLE}, rsp_rdata);
    end
    tick();
    total++;
    if ({rsp_valid, cmd_ready} !== 2'b01) begin
      bad++;
      $display("FAIL wr_done: got rv/rdy=%b want 01", {rsp_valid, cmd_ready});
    end
    $display("write 0x10 <= deadbeef: done");
  endtask

  task automatic test_read_wait_states();
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h24; cmd_wdata = 32'h0;
    PREADY = 1'b0; PRDATA = 32'hBAD0BAD0; PSLVERR = 1'b1; rsp_ready = 1'b1;
    tick();
    cmd_valid = 1'b0;
    total++;
    if ({PSEL, PENABLE} !== 2'b10) begin
      bad++;
      $display("FAIL rd_setup: got sel/en=%b want 10", {PSEL, PENABLE});
    end
    tick();
    for (int i = 0; i < 4; i++) begin
      total++;
      if ({PSEL, PENABLE, PWRITE, rsp_valid} !== 4'b1100 || PADDR !== 32'h24) begin
        bad++;
        $display("FAIL rd_access[%0d]: got sel/en/wr/rv=%b addr=%h want 1100 24", i,
                 {PSEL, PENABLE, PWRITE, rsp_valid}, PADDR);
      end
      if (i == 3) begin
        PREADY = 1'b1; PRDATA = 32'h12345678; PSLVERR = 1'b0;
      end
      tick();
    end
    PREADY = 1'b0; PRDATA = 32'h0;
    total++;
    if ({rsp_valid, rsp_err, PENABLE} !== 3'b100 || rsp_rdata !== 32'h12345678) begin
      bad++;
      $display("FAIL rd_resp: got rv/err/en=%b rdata=%h want 100 12345678", {rsp_valid, rsp_err, PENABLE}, rsp_rdata);
    end
    tick();
    total++;
    if (rsp_valid !== 1'b0 || PADDR !== 32'h24) begin
      bad++;
      $display("FAIL rd_idle_hold: got rv=%b addr=%h want 0 24", rsp_valid, PADDR);
    end
    $display("read 0x24 with 3 waits => %h: done", 32'h12345678);
  endtask

  task automatic test_error_backpressure();
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h30;
    PREADY = 1'b1; PRDATA = 32'hCAFEF00D; PSLVERR = 1'b1; rsp_ready = 1'b0;
    tick();
    cmd_addr = 32'h99;
    tick();
    tick();
    PREADY = 1'b0; PRDATA = 32'h0; PSLVERR = 1'b0;
    for (int i = 0; i < 5; i++) begin
      total++;
      if ({rsp_valid, rsp_err, cmd_ready, PSEL} !== 4'b1100 || rsp_rdata !== 32'hCAFEF00D) begin
        bad++;
        $display("FAIL err_hold[%0d]: got rv/err/rdy/sel=%b rdata=%h want 1100 cafef00d", i,
                 {rsp_valid, rsp_err, cmd_ready, PSEL}, rsp_rdata);
      end
      tick();
    end
    total++;
    if (rsp_valid !== 1'b1 || PADDR !== 32'h30) begin
      bad++;
      $display("FAIL err_busy_ignore: got rv=%b addr=%h want 1 30", rsp_valid, PADDR);
    end
    rsp_ready = 1'b1; cmd_valid = 1'b0;
    tick();
    total++;
    if ({rsp_valid, cmd_ready, PSEL} !== 3'b010) begin
      bad++;
      $display("FAIL err_taken: got rv/rdy/sel=%b want 010", {rsp_valid, cmd_ready, PSEL});
    end
    $display("read 0x30 slverr with 5 cycles backpressure: done");
  endtask

  task automatic test_reset_mid_access();
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h40; cmd_wdata = 32'h0F0F0F0F;
    PREADY = 1'b0; rsp_ready = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    total++;
    if ({PSEL, PENABLE} !== 2'b11) begin
      bad++;
      $display("FAIL rst_mid_pre: got sel/en=%b want 11", {PSEL, PENABLE});
    end
    PRESETn = 1'b0;
    #1;
    total++;
    if (cmd_ready !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid_ready: got %b want 0", cmd_ready);
    end
    tick();
    PREADY = 1'b1;
    total++;
    if ({PSEL, PENABLE, rsp_valid} !== 3'b000) begin
      bad++;
      $display("FAIL rst_mid_drop: got sel/en/rv=%b want 000", {PSEL, PENABLE, rsp_valid});
    end
    PRESETn = 1'b1;
    tick();
    total++;
    if ({PSEL, PENABLE, rsp_valid, cmd_ready} !== 4'b0001) begin
      bad++;
      $display("FAIL rst_mid_idle: got sel/en/rv/rdy=%b want 0001", {PSEL, PENABLE, rsp_valid, cmd_ready});
    end
    $display("reset during ACCESS of write 0x40: done");
  endtask

`ifdef APB_TIMEOUT_EN
  task automatic test_timeout();
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h50;
    PREADY = 1'b0; PRDATA = 32'hFFFFFFFF; PSLVERR = 1'b0; rsp_ready = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) begin
      total++;
      if ({PENABLE, rsp_valid} !== 2'b10) begin
        bad++;
        $display("FAIL to_wait[%0d]: got en/rv=%b want 10", i, {PENABLE, rsp_valid});
      end
      tick();
    end
    total++;
    if ({rsp_valid, rsp_err, PSEL, PENABLE} !== 4'b1100 || rsp_rdata !== 32'h0) begin
      bad++;
      $display("FAIL to_abort: got rv/err/sel/en=%b rdata=%h want 1100 0", {rsp_valid, rsp_err, PSEL, PENABLE}, rsp_rdata);
    end
    tick();
    cmd_valid = 1'b1; cmd_addr = 32'h54;
    tick();
    cmd_valid = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) begin
      total++;
      if ({PENABLE, rsp_valid} !== 2'b10) begin
        bad++;
        $display("FAIL to_edge_wait[%0d]: got en/rv=%b want 10", i, {PENABLE, rsp_valid});
      end
      if (i == 7) begin
        PREADY = 1'b1; PRDATA = 32'h0BADF00D;
      end
      tick();
    end
    PREADY = 1'b0;
    total++;
    if ({rsp_valid, rsp_err} !== 2'b10 || rsp_rdata !== 32'h0BADF00D) begin
      bad++;
      $display("FAIL to_edge_ok: got rv/err=%b rdata=%h want 10 0badf00d", {rsp_valid, rsp_err}, rsp_rdata);
    end
    tick();
    $display("timeout abort and last-cycle completion: done");
  endtask
`else
  task automatic test_no_timeout();
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h50;
    PREADY = 1'b0; PRDATA = 32'hFFFFFFFF; PSLVERR = 1'b0; rsp_ready = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    for (int i = 0; i < 300; i++) tick();
    total++;
    if ({PSEL, PENABLE, rsp_valid} !== 3'b110 || PADDR !== 32'h50) begin
      bad++;
      $display("FAIL nto_still_waiting: got sel/en/rv=%b addr=%h want 110 50", {PSEL, PENABLE, rsp_valid}, PADDR);
    end
    PREADY = 1'b1; PRDATA = 32'h00C0FFEE;
    tick();
    PREADY = 1'b0;
    total++;
    if ({rsp_valid, rsp_err} !== 2'b10 || rsp_rdata !== 32'h00C0FFEE) begin
      bad++;
      $display("FAIL nto_complete: got rv/err=%b rdata=%h want 10 00c0ffee", {rsp_valid, rsp_err}, rsp_rdata);
    end
    tick();
    $display("long wait without timeout: done");
  endtask
`endif

  initial begin
    PRESETn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0; PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
    test_reset();
    test_write_zero_wait();
    test_read_wait_states();
    test_error_backpressure();
    test_reset_mid_access();
`ifdef APB_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- APB requester that drives the same APB bus our slave-side interface receives.
- Converts a simple valid/ready command channel into compliant APB SETUP/ACCESS transfers.
- Returns read data and error status on a valid/ready response channel.
- Sits between testbench or CPU-side logic and any APB slave. One transfer outstanding at a time.

Parameters:
- ADDR_WIDTH, default `ADDR_WIDTH (32 if undefined): width of PADDR and cmd_addr.
- DATA_WIDTH, default `DATA_WIDTH (32 if undefined): width of PWDATA, PRDATA, cmd_wdata and rsp_rdata.
- TIMEOUT_CYCLES, default 255: ACCESS-phase wait limit; used only with APB_TIMEOUT_EN.

Ports:
- PCLK  input  1  bus clock; all logic on posedge.
- PRESETn  input  1  reset, synchronous, active-low.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  bridge accepts command this cycle.
- cmd_write  input  1  1=write, 0=read.
- cmd_addr  input  ADDR_WIDTH  transfer address.
- cmd_wdata  input  DATA_WIDTH  write data.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer takes response.
- rsp_rdata  output  DATA_WIDTH  read data; 0 for writes.
- rsp_err  output  1  PSLVERR or timeout seen.
- PSEL  output  1  slave select.
- PENABLE  output  1  access phase.
- PADDR  output  ADDR_WIDTH  address.
- PWRITE  output  1  direction.
- PWDATA  output  DATA_WIDTH  write data.
- PRDATA  input  DATA_WIDTH  read data from slave.
- PREADY  input  1  slave ready, 1 bit.
- PSLVERR  input  1  slave error.

Behaviour:
- Interface decision: one clock, PCLK. Reset PRESETn is synchronous and active-low.
- Reset values: all outputs 0; state IDLE. On any PCLK edge with PRESETn=0 the FSM returns to IDLE and PSEL/PENABLE drop. This holds mid-transfer, and any pending response is discarded.
- FSM states: IDLE, SETUP, ACCESS, RESP. All outputs are registered.
- IDLE:
  - cmd_ready=1, combinational from state.
  - On cmd_valid&cmd_ready, latch cmd_addr/cmd_write/cmd_wdata into PADDR/PWRITE/PWDATA and go to SETUP.
- SETUP (exactly 1 cycle): PSEL=1, PENABLE=0, then go to ACCESS.
- ACCESS:
  - PSEL=1, PENABLE=1.
  - PADDR/PWRITE/PWDATA held stable from SETUP until ACCESS completes.
  - PREADY=0: stay in ACCESS (unbounded wait unless timeout feature is enabled).
  - PREADY=1 at the edge:
    - rsp_rdata <= PWRITE ? 0 : PRDATA.
    - rsp_err <= PSLVERR.
    - PSEL, PENABLE <= 0; rsp_valid <= 1; go to RESP.
  - PRDATA and PSLVERR are ignored whenever PREADY=0.
- RESP:
  - rsp_valid=1; rsp_rdata/rsp_err stable until rsp_ready=1.
  - Then rsp_valid <= 0 and go to IDLE.
  - cmd_ready=0 in this state.
- PADDR/PWRITE/PWDATA keep last values while idle; they are not zeroed.
- Latency: zero-wait slave gives cmd accept at cycle N, PSEL at N+1, PENABLE at N+2, rsp_valid at N+3. Minimum 4 cycles per transfer with rsp_ready tied high.
- cmd_valid while busy is ignored, since cmd_ready=0. The command must be held until accepted.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- Defined:
  - 16-bit counter clears on SETUP and increments each ACCESS cycle with PREADY=0.
  - When the count reaches TIMEOUT_CYCLES with PREADY still 0, the transfer aborts: PSEL/PENABLE <= 0, rsp_rdata <= 0, rsp_err <= 1, go to RESP.
  - PREADY=1 on that same cycle wins, giving a normal completion.
- Not defined: no counter; ACCESS waits indefinitely for PREADY.

Test Plan:
- Reset: hold PRESETn=0 for 3 cycles with cmd_valid=1 -> all outputs 0, cmd_ready=0 during reset, then 1 in the first cycle after release.
- Write, zero wait: cmd write addr 0x10, data 0xDEADBEEF, PREADY=1 -> PSEL at +1 and PENABLE at +2 with PADDR=0x10, PWRITE=1, PWDATA=0xDEADBEEF; rsp_valid at +3 with rsp_rdata=0, rsp_err=0.
- Read, 3 wait states: read addr 0x24, PREADY low for 3 ACCESS cycles then high with PRDATA=0x12345678 -> PENABLE high for 4 cycles, PADDR stable throughout, rsp_rdata=0x12345678.
- Error plus response backpressure: read with PSLVERR=1 on the PREADY cycle, rsp_ready low for 5 cycles -> rsp_err=1, rsp_valid/rsp_rdata stable all 5 cycles, cmd_ready=0 until the response is taken.
- Reset mid-ACCESS: assert PRESETn=0 while PENABLE=1 -> PSEL/PENABLE=0 after the next edge, no rsp_valid, IDLE after release.
- APB_TIMEOUT_EN with TIMEOUT_CYCLES=8: PREADY held 0 -> abort after 8 wait cycles with rsp_err=1, rsp_rdata=0. Repeat with PREADY=1 on cycle 8 -> normal completion, rsp_err=0.
